// File: rtl/power_trig_pkg.sv
// power_trig_pkg: shared widths, FSM state type and sample helper
// for the power trigger detector.
package power_trig_pkg;

  localparam int NSAMP  = 8;
  localparam int SAMP_W = 12;
  localparam int SQ_W   = 23;
  localparam int ESUM_W = 26;
  localparam int DAT_W  = NSAMP * SAMP_W;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_t;

  function automatic logic signed [SAMP_W-1:0] sample(
    input logic [DAT_W-1:0] vec,
    input int               k
  );
    return vec[k*SAMP_W +: SAMP_W];
  endfunction

endpackage

// File: rtl/energy_sum8.sv
// energy_sum8: squares NSAMP signed samples, then sums them.
// Two registered stages: squares, then the adder tree.
module energy_sum8
  import power_trig_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DAT_W-1:0]  dat_i,
  output logic [ESUM_W-1:0] e_o
);

  logic [SQ_W-1:0]   r_sq [NSAMP];
  logic [SQ_W-1:0]   w_sq [NSAMP];
  logic [ESUM_W-1:0] w_sum;
  logic [ESUM_W-1:0] r_e;

  // (-2048)^2 still fits SQ_W unsigned bits
  function automatic logic [SQ_W-1:0] square(
    input logic signed [SAMP_W-1:0] s
  );
    logic signed [SQ_W:0] x;
    x = {{(SQ_W+1-SAMP_W){s[SAMP_W-1]}}, s};
    return SQ_W'(x * x);
  endfunction

  // square every sample of the incoming vector
  always_comb begin
    for (int k = 0; k < NSAMP; k++) begin
      w_sq[k] = square(sample(dat_i, k));
    end
  end

  // add the registered squares into one energy value
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NSAMP; k++) begin
      w_sum = w_sum + ESUM_W'(r_sq[k]);
    end
  end

  // stage 1 squares and stage 2 sum registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int k = 0; k < NSAMP; k++) begin
        r_sq[k] <= '0;
      end
      r_e <= '0;
    end else begin
      for (int k = 0; k < NSAMP; k++) begin
        r_sq[k] <= w_sq[k];
      end
      r_e <= w_sum;
    end
  end

  assign e_o = r_e;

endmodule

// File: rtl/power_trigger_detector.sv
// power_trigger_detector: windowed energy, threshold trigger, hold-off.
// Optional peak hold enabled by defining POWER_TRIG_PEAK_HOLD_EN.
module power_trigger_detector
  import power_trig_pkg::*;
#(
  parameter int NWIN     = 4,
  parameter int ENERGY_W = 32,
  parameter int HOLDOFF  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DAT_W-1:0]    dat_i,
  input  logic [ENERGY_W-1:0] thresh_i,
  input  logic                trig_en_i,
  output logic                trig_o,
  output logic [ENERGY_W-1:0] energy_o,
  output logic [CNT_W-1:0]    trig_count_o
`ifdef POWER_TRIG_PEAK_HOLD_EN
  ,
  input  logic                clr_peak_i,
  output logic [ENERGY_W-1:0] peak_o
`endif
);

  localparam int FILL_W = $clog2(NWIN);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic [DAT_W-1:0]    r_dat;
  logic [2:0]          r_vld;
  logic [ESUM_W-1:0]   w_e;
  logic [ESUM_W-1:0]   r_hist [NWIN];
  logic [ENERGY_W-1:0] r_sum;
  logic                w_hit;
  trig_state_t         r_state;
  logic [FILL_W-1:0]   r_fill;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_trig;
  logic [CNT_W-1:0]    r_cnt;

  // input register; r_vld marks real vectors moving down the pipe
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_dat <= '0;
      r_vld <= '0;
    end else begin
      r_dat <= dat_i;
      r_vld <= {r_vld[1:0], 1'b1};
    end
  end

  energy_sum8 u_esum (
    .aclk    (aclk),
    .aresetn (aresetn),
    .dat_i   (r_dat),
    .e_o     (w_e)
  );

  // sliding window: add the newest E, drop the oldest
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int k = 0; k < NWIN; k++) begin
        r_hist[k] <= '0;
      end
      r_sum <= '0;
    end else begin
      r_hist[0] <= w_e;
      for (int k = 1; k < NWIN; k++) begin
        r_hist[k] <= r_hist[k-1];
      end
      r_sum <= r_sum + ENERGY_W'(w_e)
             - ENERGY_W'(r_hist[NWIN-1]);
    end
  end

  assign w_hit = (r_sum > thresh_i);

  // trigger FSM; the registered trig_o is the stage-4 compare
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_FILL;
      r_fill  <= '0;
      r_hold  <= '0;
      r_trig  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_trig <= 1'b0;
      unique case (r_state)
        ST_FILL: begin
          if (r_vld[2]) begin
            if (r_fill == FILL_W'(NWIN-1)) begin
              r_state <= ST_ARMED;
            end
            r_fill <= r_fill + FILL_W'(1);
          end
        end
        ST_ARMED: begin
          if (w_hit && trig_en_i) begin
            r_trig  <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_hold  <= HOLD_W'(HOLDOFF-1);
            r_state <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (r_hold == '0) begin
            r_state <= ST_ARMED;
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign trig_o       = r_trig;
  assign energy_o     = r_sum;
  assign trig_count_o = r_cnt;

`ifdef POWER_TRIG_PEAK_HOLD_EN
  logic [ENERGY_W-1:0] r_peak;

  // running max of the window sum; clear has priority
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_peak <= '0;
    end else if (clr_peak_i) begin
      r_peak <= (r_state == ST_FILL) ? '0 : r_sum;
    end else if (r_state != ST_FILL && r_sum > r_peak) begin
      r_peak <= r_sum;
    end
  end

  assign peak_o = r_peak;
`endif

endmodule
